moving_average: RTL and testbench



---
 rtl/audio_pkg.sv | 10 +
 rtl/sample_ring.sv | 36 +++
 rtl/moving_average.sv | 84 ++++++++
 tb/tb_moving_average.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types and constants, common to the delay/divide stage and the
// moving-average filter.
package audio_pkg;

  localparam int unsigned SAMPLE_W       = 24;
  localparam int unsigned LOG2_N_DEFAULT = 3;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_ring.sv
// N-deep circular sample buffer; the entry at the write pointer is the oldest one,
// so it is read combinationally just before being overwritten.
module sample_ring
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH      = SAMPLE_W,
  parameter int unsigned DEPTH_LOG2 = LOG2_N_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_oldest
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;

  always_ff @(posedge Clock) begin
    if (!Reset_n || clear) begin
      r_wr_ptr <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[r_wr_ptr] <= wdata;
      r_wr_ptr        <= r_wr_ptr + DEPTH_LOG2'(1);
    end
  end

  assign rdata_oldest = r_mem[r_wr_ptr];

endmodule

// File: rtl/moving_average.sv
// Running-sum moving average: each sample is pre-scaled by 1/N, and the sum tracks
// newest-in minus oldest-out. Outputs are partial sums while the window fills.
module moving_average
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH  = SAMPLE_W,
  parameter int unsigned LOG2_N = LOG2_N_DEFAULT
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_sample,
  input  logic                    flush,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_sample,
  output logic                    primed
);

  localparam int unsigned N  = 2 ** LOG2_N;
  localparam int unsigned SW = WIDTH + LOG2_N;
  localparam logic [LOG2_N:0] FillMax = (LOG2_N + 1)'(N);

  logic                    w_accept;
  logic        [WIDTH-1:0] w_bias;
  logic signed [WIDTH-1:0] w_biased;
  logic signed [WIDTH-1:0] w_div;
  logic signed [WIDTH-1:0] w_old;
  logic signed [SW-1:0]    w_sum_next;

  logic signed [SW-1:0]    r_sum;
  logic        [LOG2_N:0]  r_fill;
  logic                    r_out_valid;
  logic signed [WIDTH-1:0] r_out_sample;

  assign w_accept = in_valid & ~flush;

  // Biasing negatives by N-1 before the arithmetic shift makes it truncate toward zero.
  assign w_bias   = {{(WIDTH - LOG2_N){1'b0}}, {LOG2_N{in_sample[WIDTH-1]}}};
  assign w_biased = in_sample + w_bias;
  assign w_div    = w_biased >>> LOG2_N;

  assign w_sum_next = r_sum + {{LOG2_N{w_div[WIDTH-1]}}, w_div}
                            - {{LOG2_N{w_old[WIDTH-1]}}, w_old};

  sample_ring #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (LOG2_N)
  ) u_ring (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .clear        (flush),
    .we           (w_accept),
    .wdata        (w_div),
    .rdata_oldest (w_old)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_sum        <= '0;
      r_fill       <= '0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
    end else if (flush) begin
      // out_sample deliberately holds across a flush.
      r_sum       <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_sum        <= w_sum_next;
        r_out_sample <= w_sum_next[WIDTH-1:0];
        if (r_fill != FillMax) begin
          r_fill <= r_fill + (LOG2_N + 1)'(1);
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;
  assign primed     = (r_fill == FillMax);

endmodule

// File: tb/tb_moving_average.sv
// Vector table plus model-checked random stream for moving_average; expected outputs
// are queued when a cycle is driven and popped after the clock edge.
module tb_moving_average;
  import audio_pkg::*;

  localparam int W = 24;
  localparam int N = 8;

  logic    Clock = 1'b0;
  logic    Reset_n = 1'b0;
  logic    in_valid = 1'b0;
  logic    flush = 1'b0;
  sample_t in_sample = '0;
  logic    out_valid;
  sample_t out_sample;
  logic    primed;

  moving_average #(
    .WIDTH  (W),
    .LOG2_N (3)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .primed     (primed)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic    v;
    sample_t s;
    logic    f;
    logic    rn;
    logic    ev;
    sample_t es;
    logic    ep;
  } vec_t;

  typedef struct {
    logic    ev;
    sample_t es;
    logic    ep;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic v, input int s, input logic f, input logic rn,
                              input logic ev, input int es, input logic ep);
    vec_t x;
    x.v = v; x.s = W'(s); x.f = f; x.rn = rn;
    x.ev = ev; x.es = W'(es); x.ep = ep;
    tbl.push_back(x);
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty at vector %0d", n_vec);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (out_valid !== e.ev) begin
      n_bad++;
      $display("FAIL out_valid vec %0d: got %b want %b", n_vec, out_valid, e.ev);
    end
    if (out_sample !== e.es) begin
      n_bad++;
      $display("FAIL out_sample vec %0d: got %0d want %0d", n_vec, out_sample, e.es);
    end
    if (primed !== e.ep) begin
      n_bad++;
      $display("FAIL primed vec %0d: got %b want %b", n_vec, primed, e.ep);
    end
  endtask

  task automatic apply(input vec_t x);
    exp_t e;
    @(negedge Clock);
    in_valid  = x.v;
    in_sample = x.s;
    flush     = x.f;
    Reset_n   = x.rn;
    e.ev = x.ev; e.es = x.es; e.ep = x.ep;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    check_out();
  endtask

  // Reference state for the random stream; uses plain integer division.
  int m_buf[N];
  int m_ptr, m_sum, m_fill, m_last;

  initial begin
    vec_t x;
    logic signed [W-1:0] rs;
    int xi, d;

    // Reset, idle.
    add(1'b1, 400, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    // Single sample, then hold.
    add(1'b1, 128, 1'b0, 1'b1, 1'b1, 16, 1'b0);
    add(1'b0, 0, 1'b0, 1'b1, 1'b0, 16, 1'b0);
    add(1'b0, 0, 1'b1, 1'b1, 1'b0, 16, 1'b0);
    // Fill with 800s, then wrap.
    for (int k = 1; k <= 8; k++) add(1'b1, 800, 1'b0, 1'b1, 1'b1, 100 * k, k == 8);
    add(1'b1, 800, 1'b0, 1'b1, 1'b1, 800, 1'b1);
    // Drain with zeros, then truncate-toward-zero.
    for (int k = 1; k <= 8; k++) add(1'b1, 0, 1'b0, 1'b1, 1'b1, 800 - 100 * k, 1'b1);
    add(1'b1, -1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    add(1'b1, -9, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    // Full-scale extremes from a clean window.
    add(1'b0, 0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    for (int k = 1; k <= 8; k++) add(1'b1, 8388607, 1'b0, 1'b1, 1'b1, 1048575 * k, k == 8);
    for (int k = 1; k <= 8; k++)
      add(1'b1, -8388608, 1'b0, 1'b1, 1'b1, 8388600 - 2097151 * k, 1'b1);
    // Flush beats in_valid; reset beats in_valid.
    add(1'b1, 400, 1'b1, 1'b1, 1'b0, -8388608, 1'b0);
    add(1'b1, 80, 1'b0, 1'b1, 1'b1, 10, 1'b0);
    add(1'b1, 400, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    add(1'b1, 80, 1'b0, 1'b1, 1'b1, 10, 1'b0);
    add(1'b0, 0, 1'b1, 1'b1, 1'b0, 10, 1'b0);

    foreach (tbl[i]) apply(tbl[i]);

    // Random stream with gaps, checked against the reference model.
    for (int i = 0; i < N; i++) m_buf[i] = 0;
    m_ptr = 0; m_sum = 0; m_fill = 0; m_last = 10;
    for (int i = 0; i < 60; i++) begin
      rs   = W'($urandom);
      xi   = rs;
      x.v  = ($urandom_range(0, 3) != 0);
      x.s  = rs;
      x.f  = 1'b0;
      x.rn = 1'b1;
      if (x.v) begin
        d = xi / N;
        m_sum = m_sum + d - m_buf[m_ptr];
        m_buf[m_ptr] = d;
        m_ptr = (m_ptr + 1) % N;
        if (m_fill < N) m_fill++;
        m_last = m_sum;
      end
      x.ev = x.v;
      x.es = W'(m_last);
      x.ep = (m_fill == N);
      apply(x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
